pipeline_hazard_ctrl: RTL and testbench

Central hazard and sequencing controller for the 5-stage pipeline. It generates the `stall`/`flush` pair for each of the four pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB), the PC enable and the redirect select. It resolves instruction-memory waits, data-memory waits, load-use hazards, branch/jump redirects and halt. A small FSM tracks pending redirects across instruction-fetch misses and latches the halt condition.

---
 rtl/pipeline_hazard_ctrl_if.sv | 24 ++
 rtl/pipeline_hazard_ctrl.sv | 68 ++++++
 tb/tb_pipeline_hazard_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard inputs from the pipeline and the latch/PC controls returned to it.
interface pipeline_hazard_ctrl_if #(parameter int STALL_CNT_W = 32);
   logic ihit, dhit, exmem_dREN, exmem_dWEN, idex_dREN;
   logic [4:0] idex_RW, ifid_rs, ifid_rt;
   logic branch_taken, jump, memwb_halt;
   logic ifid_stall, ifid_flush, idex_stall, idex_flush;
   logic exmem_stall, exmem_flush, memwb_stall, memwb_flush;
   logic pc_en, pc_redirect, halt_out;
   logic [STALL_CNT_W-1:0] stall_count;
   modport master (
      output ihit, dhit, exmem_dREN, exmem_dWEN, idex_dREN, idex_RW, ifid_rs, ifid_rt,
      output branch_taken, jump, memwb_halt,
      input ifid_stall, ifid_flush, idex_stall, idex_flush,
      input exmem_stall, exmem_flush, memwb_stall, memwb_flush,
      input pc_en, pc_redirect, halt_out, stall_count
   );
   modport slave (
      input ihit, dhit, exmem_dREN, exmem_dWEN, idex_dREN, idex_RW, ifid_rs, ifid_rt,
      input branch_taken, jump, memwb_halt,
      output ifid_stall, ifid_flush, idex_stall, idex_flush,
      output exmem_stall, exmem_flush, memwb_stall, memwb_flush,
      output pc_en, pc_redirect, halt_out, stall_count
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/PC sequencing for the 5-stage pipeline.
// Define PIPE_STALL_PERF_EN to build the saturating stall-cycle counter.
module pipeline_hazard_ctrl #(parameter int STALL_CNT_W = 32) (
   input logic clk,
   input logic rst,
   pipeline_hazard_ctrl_if.slave bus
);
   typedef enum logic [1:0] {RUN, REDIR_PEND, HALTED} state_e;
   state_e state_q, state_d;
   logic halt_q;
   logic mem_busy, load_use, redir, pc_en;
   logic [3:0] stall, flush;
   assign mem_busy = (bus.exmem_dREN | bus.exmem_dWEN) & ~bus.dhit;
   assign load_use = bus.idex_dREN & (bus.idex_RW != 5'd0) &
                     (bus.idex_RW == bus.ifid_rs | bus.idex_RW == bus.ifid_rt);
   assign redir = bus.branch_taken | bus.jump;
   // stall/flush bit 3 = IF/ID down to bit 0 = MEM/WB
   always_comb begin
      state_d = state_q;
      stall = '0;
      flush = '0;
      pc_en = 1'b0;
      bus.pc_redirect = 1'b0;
      if (rst) flush = '1;
      else if (state_q == HALTED || bus.memwb_halt) begin
         stall = '1;
         state_d = HALTED;
      end else if (mem_busy) begin
         stall = 4'b1110;
         flush = 4'b0001;
      end else if (redir) begin
         pc_en = 1'b1;
         bus.pc_redirect = 1'b1;
         flush = {1'b1, bus.branch_taken, 2'b00};
         state_d = bus.ihit ? RUN : REDIR_PEND;
      end else if (state_q == REDIR_PEND || !bus.ihit) begin
         flush = 4'b1000;
         state_d = bus.ihit ? RUN : state_q;
      end else if (load_use) begin
         stall = 4'b1000;
         flush = 4'b0100;
      end else pc_en = 1'b1;
   end
   assign {bus.ifid_stall, bus.idex_stall, bus.exmem_stall, bus.memwb_stall} = stall & ~flush;
   assign {bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.memwb_flush} = flush;
   assign bus.pc_en = pc_en;
   assign bus.halt_out = halt_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         halt_q <= 1'b0;
      end else begin
         state_q <= state_d;
         halt_q <= state_d == HALTED;
      end
   end
`ifdef PIPE_STALL_PERF_EN
   logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
   assign cnt_d = (!pc_en && state_q != HALTED && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
   assign bus.stall_count = cnt_q;
`else
   assign bus.stall_count = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and randomized checks against a priority-rule reference model.
module tb_pipeline_hazard_ctrl;
   localparam int W = 4;
   localparam int CMAX = 2 ** W - 1;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_chk = 0;
   int n_fail = 0;
   int m_st = 0;
   int m_cnt = 0;
   pipeline_hazard_ctrl_if #(.STALL_CNT_W(W)) bus ();
   pipeline_hazard_ctrl #(.STALL_CNT_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [9:0] dut_ctl();
      return {bus.ifid_stall, bus.ifid_flush, bus.idex_stall, bus.idex_flush,
              bus.exmem_stall, bus.exmem_flush, bus.memwb_stall, bus.memwb_flush,
              bus.pc_en, bus.pc_redirect};
   endfunction

   function automatic int exp_cnt();
`ifdef PIPE_STALL_PERF_EN
      return m_cnt;
`else
      return 0;
`endif
   endfunction

   // model states: 0 RUN, 1 REDIR_PEND, 2 HALTED
   function automatic logic [9:0] model_out(input int st);
      bit busy, lu, rd;
      busy = (bus.exmem_dREN || bus.exmem_dWEN) && !bus.dhit;
      lu = bus.idex_dREN && bus.idex_RW != 0 && (bus.idex_RW == bus.ifid_rs || bus.idex_RW == bus.ifid_rt);
      rd = bus.branch_taken || bus.jump;
      if (st == 2 || bus.memwb_halt) return 10'b10_10_10_10_00;
      if (busy) return 10'b10_10_10_01_00;
      if (rd) return {3'b010, bus.branch_taken, 4'b0000, 2'b11};
      if (st == 1 || !bus.ihit) return 10'b01_00_00_00_00;
      if (lu) return 10'b10_01_00_00_00;
      return 10'b00_00_00_00_10;
   endfunction

   function automatic int model_next(input int st);
      bit busy;
      busy = (bus.exmem_dREN || bus.exmem_dWEN) && !bus.dhit;
      if (st == 2 || bus.memwb_halt) return 2;
      if (busy) return st;
      if (bus.branch_taken || bus.jump) return bus.ihit ? 0 : 1;
      if (st == 1 && !bus.ihit) return 1;
      return 0;
   endfunction

   task automatic drive(input logic ih, dh, drn, dwn, irn, input logic [4:0] rw, rs, rt,
                        input logic br, jp, hl);
      bus.ihit = ih; bus.dhit = dh; bus.exmem_dREN = drn; bus.exmem_dWEN = dwn;
      bus.idex_dREN = irn; bus.idex_RW = rw; bus.ifid_rs = rs; bus.ifid_rt = rt;
      bus.branch_taken = br; bus.jump = jp; bus.memwb_halt = hl;
   endtask

   task automatic rand_drive(input int halt_odds);
      drive($urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0, 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, halt_odds) == 0);
   endtask

   task automatic cyc();
      logic [9:0] e;
      int nx;
      #1;
      e = model_out(m_st);
      check("ctl", {54'd0, dut_ctl()}, {54'd0, e});
      check("halt_out", {63'd0, bus.halt_out}, {63'd0, m_st == 2});
      check("stall_count", 64'(bus.stall_count), 64'(exp_cnt()));
      nx = model_next(m_st);
      @(posedge clk);
      if (m_st != 2 && !e[1] && m_cnt < CMAX) m_cnt++;
      m_st = nx;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check("rst_ctl", {54'd0, dut_ctl()}, {54'd0, 10'b01_01_01_01_00});
      check("rst_halt", {63'd0, bus.halt_out}, 64'd0);
      check("rst_cnt", 64'(bus.stall_count), 64'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      m_st = 0;
      m_cnt = 0;
   endtask

   initial begin
      drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      do_reset();
      drive(1, 1, 0, 0, 1, 5, 0, 5, 0, 0, 0);
      #1 check("lu_pc_en", {63'd0, bus.pc_en}, 64'd0);
      cyc();
      drive(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      #1 check("lu_rw0_pc_en", {63'd0, bus.pc_en}, 64'd1);
      cyc();
      do_reset();
      repeat (3) begin
         drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
         cyc();
      end
      drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc();
`ifdef PIPE_STALL_PERF_EN
      #1 check("dwait_cnt", 64'(bus.stall_count), 64'd3);
`else
      #1 check("dwait_cnt", 64'(bus.stall_count), 64'd0);
`endif
      drive(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      #1 check("br_redirect", {63'd0, bus.pc_redirect}, 64'd1);
      cyc();
      repeat (2) begin
         drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
         cyc();
      end
      drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1 check("pend_flush", {63'd0, bus.ifid_flush}, 64'd1);
      cyc();
      #1 check("run_flush", {63'd0, bus.ifid_flush}, 64'd0);
      cyc();
      repeat (2) begin
         drive(1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
         cyc();
      end
      drive(1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0);
      cyc();
      drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      cyc();
      repeat (10) begin
         rand_drive(3);
         #1 check("halted", {63'd0, bus.halt_out}, 64'd1);
         cyc();
      end
      do_reset();
      repeat (20) begin
         drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
         cyc();
      end
`ifdef PIPE_STALL_PERF_EN
      #1 check("sat_cnt", 64'(bus.stall_count), 64'(CMAX));
`else
      #1 check("sat_cnt", 64'(bus.stall_count), 64'd0);
`endif
      for (int c = 0; c < 30; c++) begin
         do_reset();
         repeat (40) begin
            rand_drive(149);
            cyc();
         end
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
